// File: rtl/serial_subtractor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial subtractor computing diff = a - b - bin, one bit
//               per clock, LSB first, through a single full-subtractor cell
//               and a borrow flip-flop. A start/busy/done handshake frames
//               each operation. The result is published after WIDTH cycles.
//
// Ports       : clk    - clock, rising edge
//               rst    - asynchronous active-high reset
//               start  - request, accepted only while idle
//               a      - minuend [WIDTH-1:0], captured on accept
//               b      - subtrahend [WIDTH-1:0], captured on accept
//               bin    - borrow-in, captured on accept
//               busy   - operation in progress
//               done   - one-cycle completion pulse
//               diff   - result [WIDTH-1:0], held until next completion
//               bout   - final borrow-out, held until next completion
//               ovf    - signed overflow (only with SERIAL_SUB_OVF_EN)
//
// Options     : SERIAL_SUB_OVF_EN - when defined, adds the ovf output and
//               its register.
//
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] c_last_bit = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [WIDTH-1:0] ra_q,    ra_d;
   logic [WIDTH-1:0] rb_q,    rb_d;
   logic             br_q,    br_d;
   logic [WIDTH-1:0] res_q,   res_d;
   logic [WIDTH-1:0] diff_q,  diff_d;
   logic             bout_q,  bout_d;
   logic             done_q,  done_d;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf_q,   ovf_d;
`endif

   // Full-subtractor cell operating on the current LSBs.
   logic w_bit;
   logic w_borrow;

   assign w_bit    = ra_q[0] ^ rb_q[0] ^ br_q;
   assign w_borrow = (~ra_q[0] & rb_q[0]) | (~ra_q[0] & br_q) | (rb_q[0] & br_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      br_d    = br_q;
      res_d   = res_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      done_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_d   = ovf_q;
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               ra_d    = a;
               rb_d    = b;
               br_d    = bin;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            ra_d  = ra_q >> 1;
            rb_d  = rb_q >> 1;
            br_d  = w_borrow;
            // Result fills from the top so that after WIDTH shifts bit 0
            // of the result sits in bit 0 of the register.
            res_d = {w_bit, res_q[WIDTH-1:1]};
            cnt_d = cnt_q + c_cnt_one;

            if (cnt_q == c_last_bit) begin
               // Publish only the completed word; intermediate bits never
               // reach diff.
               diff_d  = {w_bit, res_q[WIDTH-1:1]};
               bout_d  = w_borrow;
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
`ifdef SERIAL_SUB_OVF_EN
               // br_q here is the borrow into the MSB.
               ovf_d   = br_q ^ w_borrow;
`endif
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ra_q    <= '0;
         rb_q    <= '0;
         br_q    <= 1'b0;
         res_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         br_q    <= br_d;
         res_q   <= res_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy = (state_q == SHIFT);
   assign done = done_q;
   assign diff = diff_q;
   assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule
`default_nettype wire
